// File: rtl/vrampx_cpu_read_port.sv
// CPU read-back port for the pixel framebuffer in external SRAM (100MHz arbiter domain).
// Serialises one read behind the CPU write FIFO and GPU blanking, then performs a single SRAM read.
module vrampx_cpu_read_port #(
    parameter int          ADDR_WIDTH       = 17,
    parameter int          SRAM_ADDR_WIDTH  = 19,
    parameter int unsigned PIXELS           = 76800,
    parameter int          READ_WAIT_CYCLES = 2
) (
    input  logic                       clk100,
    input  logic                       reset,
    input  logic                       req,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    output logic                       busy,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_data,
    input  logic                       wr_fifo_empty,
    input  logic                       blank,
    output logic                       arb_req,
    input  logic                       arb_grant,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic                       sram_cs_n,
    output logic                       sram_oe_n,
    input  logic [7:0]                 sram_dq_in
);

    localparam int CNT_W = (READ_WAIT_CYCLES > 1) ? $clog2(READ_WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_ORDER = 3'd1,
        ST_WAIT_GRANT = 3'd2,
        ST_READ       = 3'd3,
        ST_RESP       = 3'd4
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic [ADDR_WIDTH-1:0]      addr_r;
    logic [ADDR_WIDTH-1:0]      addr_nxt_s;
    logic [CNT_W-1:0]           cnt_r;
    logic [CNT_W-1:0]           cnt_nxt_s;
    logic                       busy_r;
    logic                       busy_nxt_s;
    logic                       rsp_valid_r;
    logic                       rsp_valid_nxt_s;
    logic [7:0]                 rsp_data_r;
    logic [7:0]                 rsp_data_nxt_s;
    logic                       arb_req_r;
    logic                       arb_req_nxt_s;
    logic                       cs_n_r;
    logic                       cs_n_nxt_s;
    logic                       oe_n_r;
    logic                       oe_n_nxt_s;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_r;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_nxt_s;
    logic                       in_range_s;

    assign in_range_s = (32'(req_addr) < PIXELS);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        next_state_s    = state_r;
        addr_nxt_s      = addr_r;
        cnt_nxt_s       = cnt_r;
        rsp_valid_nxt_s = 1'b0;
        rsp_data_nxt_s  = rsp_data_r;
        arb_req_nxt_s   = arb_req_r;
        cs_n_nxt_s      = 1'b1;
        oe_n_nxt_s      = 1'b1;
        sram_addr_nxt_s = sram_addr_r;
        // busy covers the response cycle and drops the cycle after it
        if (rsp_valid_r) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (req && !busy_r) begin
                    addr_nxt_s = req_addr;
                    busy_nxt_s = 1'b1;
                    if (in_range_s) begin
                        next_state_s = ST_WAIT_ORDER;
                    end else begin
                        next_state_s   = ST_RESP;
                        rsp_data_nxt_s = 8'h00;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_ORDER: begin
                if (wr_fifo_empty && blank) begin
                    next_state_s  = ST_WAIT_GRANT;
                    arb_req_nxt_s = 1'b1;
                end else begin
                    next_state_s = ST_WAIT_ORDER;
                end
            end
            ST_WAIT_GRANT: begin
                // a grant wins over a same-cycle blank drop: the bus is ours
                if (arb_grant) begin
                    next_state_s    = ST_READ;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    cs_n_nxt_s      = 1'b0;
                    oe_n_nxt_s      = 1'b0;
                    sram_addr_nxt_s = SRAM_ADDR_WIDTH'(addr_r);
                end else if (!blank) begin
                    next_state_s  = ST_WAIT_ORDER;
                    arb_req_nxt_s = 1'b0;
                end else begin
                    next_state_s = ST_WAIT_GRANT;
                end
            end
            ST_READ: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s   = ST_RESP;
                    rsp_data_nxt_s = sram_dq_in;
                end else begin
                    next_state_s = ST_READ;
                    cnt_nxt_s    = cnt_r + CNT_W'(1);
                    cs_n_nxt_s   = 1'b0;
                    oe_n_nxt_s   = 1'b0;
                end
            end
            ST_RESP: begin
                next_state_s    = ST_IDLE;
                rsp_valid_nxt_s = 1'b1;
                arb_req_nxt_s   = 1'b0;
            end
            default: begin
                next_state_s  = ST_IDLE;
                arb_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight request.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            arb_req_r   <= 1'b0;
            cs_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            sram_addr_r <= {SRAM_ADDR_WIDTH{1'b0}};
        end else begin
            state_r     <= next_state_s;
            addr_r      <= addr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            busy_r      <= busy_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            arb_req_r   <= arb_req_nxt_s;
            cs_n_r      <= cs_n_nxt_s;
            oe_n_r      <= oe_n_nxt_s;
            sram_addr_r <= sram_addr_nxt_s;
        end
    end

    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign arb_req   = arb_req_r;
    assign sram_cs_n = cs_n_r;
    assign sram_oe_n = oe_n_r;
    assign sram_addr = sram_addr_r;

endmodule

// File: tb/tb_vrampx_cpu_read_port.sv
// Directed self-checking bench for vrampx_cpu_read_port with a small SRAM and arbiter model.
module tb_vrampx_cpu_read_port;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        req;
    logic [16:0] req_addr;
    logic        busy;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        wr_fifo_empty;
    logic        blank;
    logic        arb_req;
    logic        arb_grant;
    logic [18:0] sram_addr;
    logic        sram_cs_n;
    logic        sram_oe_n;
    logic [7:0]  sram_dq_in;

    logic [7:0]  mem [0:1023];
    logic        grant_en;
    int          checks = 0;
    int          failures = 0;
    int          rsp_cnt = 0;
    int          arb_cnt = 0;
    int          cs_cnt = 0;

    vrampx_cpu_read_port dut (
        .clk100        (clk100),
        .reset         (reset),
        .req           (req),
        .req_addr      (req_addr),
        .busy          (busy),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .wr_fifo_empty (wr_fifo_empty),
        .blank         (blank),
        .arb_req       (arb_req),
        .arb_grant     (arb_grant),
        .sram_addr     (sram_addr),
        .sram_cs_n     (sram_cs_n),
        .sram_oe_n     (sram_oe_n),
        .sram_dq_in    (sram_dq_in)
    );

    always #5 clk100 = ~clk100;

    assign arb_grant  = arb_req & grant_en;
    assign sram_dq_in = (!sram_cs_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 8'hFF;

    always @(posedge clk100) begin
        if (rsp_valid) rsp_cnt++;
        if (arb_req) arb_cnt++;
        if (!sram_cs_n) cs_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic issue_req(input logic [16:0] a);
        for (int i = 0; i < 20 && busy; i++) tick();
        req      = 1'b1;
        req_addr = a;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_rsp(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        int  lat;
        bit  ok;
        int  snap_rsp, snap_arb, snap_cs;

        for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
        mem[100]  = 8'h5A;
        mem[1023] = 8'hC3;
        mem[200]  = 8'h11;
        mem[300]  = 8'h3C;
        mem[400]  = 8'h96;
        mem[500]  = 8'h69;

        reset = 1'b1; req = 1'b0; req_addr = 17'd0;
        wr_fifo_empty = 1'b1; blank = 1'b1; grant_en = 1'b1;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'h00);
        check_eq("rst_arb_req", 32'(arb_req), 32'd0);
        check_eq("rst_cs_n", 32'(sram_cs_n), 32'd1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("rst_sram_addr", 32'(sram_addr), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: basic in-range read
        snap_cs = cs_cnt;
        issue_req(17'd100);
        check_eq("t1_busy_after_accept", 32'(busy), 32'd1);
        wait_rsp(lat, ok);
        check_eq("t1_rsp_seen", 32'(ok), 32'd1);
        check_eq("t1_latency", 32'(lat), 32'd5);
        check_eq("t1_data", 32'(rsp_data), 32'h5A);
        check_eq("t1_busy_in_rsp", 32'(busy), 32'd1);
        tick();
        check_eq("t1_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check_eq("t1_busy_released", 32'(busy), 32'd0);
        check_eq("t1_cs_low_cycles", 32'(cs_cnt - snap_cs), 32'd2);
        check_eq("t1_arb_req_dropped", 32'(arb_req), 32'd0);

        // 1b: last valid pixel
        issue_req(17'd76799);
        wait_rsp(lat, ok);
        check_eq("t1b_latency", 32'(lat), 32'd5);
        check_eq("t1b_data", 32'(rsp_data), 32'hC3);
        tick();

        // 2: first out-of-range address
        snap_arb = arb_cnt; snap_cs = cs_cnt;
        issue_req(17'd76800);
        wait_rsp(lat, ok);
        check_eq("t2_rsp_seen", 32'(ok), 32'd1);
        check_eq("t2_latency", 32'(lat), 32'd1);
        check_eq("t2_data", 32'(rsp_data), 32'h00);
        tick();
        check_eq("t2_no_arb_req", 32'(arb_cnt - snap_arb), 32'd0);
        check_eq("t2_no_cs", 32'(cs_cnt - snap_cs), 32'd0);

        // 3: write FIFO not empty holds the read off
        wr_fifo_empty = 1'b0;
        snap_arb = arb_cnt;
        issue_req(17'd200);
        for (int i = 0; i < 20; i++) tick();
        check_eq("t3_no_arb_while_fifo", 32'(arb_cnt - snap_arb), 32'd0);
        check_eq("t3_still_busy", 32'(busy), 32'd1);
        mem[200] = 8'h77;
        wr_fifo_empty = 1'b1;
        wait_rsp(lat, ok);
        check_eq("t3_latency_after_drain", 32'(lat), 32'd5);
        check_eq("t3_post_write_data", 32'(rsp_data), 32'h77);
        tick();

        // 4: blanking gate and grant-less retreat
        blank = 1'b0; grant_en = 1'b0;
        snap_arb = arb_cnt;
        issue_req(17'd300);
        for (int i = 0; i < 50; i++) tick();
        check_eq("t4_no_arb_outside_blank", 32'(arb_cnt - snap_arb), 32'd0);
        blank = 1'b1;
        tick();
        check_eq("t4_arb_req_raised", 32'(arb_req), 32'd1);
        tick();
        check_eq("t4_arb_req_held", 32'(arb_req), 32'd1);
        blank = 1'b0;
        tick();
        check_eq("t4_arb_req_dropped", 32'(arb_req), 32'd0);
        check_eq("t4_no_cs_yet", 32'(sram_cs_n), 32'd1);
        blank = 1'b1; grant_en = 1'b1;
        wait_rsp(lat, ok);
        check_eq("t4_retry_latency", 32'(lat), 32'd5);
        check_eq("t4_data", 32'(rsp_data), 32'h3C);
        tick();

        // 5: request while busy is ignored
        snap_rsp = rsp_cnt;
        issue_req(17'd400);
        tick();
        req = 1'b1; req_addr = 17'd500;
        tick();
        req = 1'b0;
        wait_rsp(lat, ok);
        check_eq("t5_first_data", 32'(rsp_data), 32'h96);
        for (int i = 0; i < 10; i++) tick();
        check_eq("t5_single_rsp", 32'(rsp_cnt - snap_rsp), 32'd1);
        check_eq("t5_idle", 32'(busy), 32'd0);
        issue_req(17'd500);
        wait_rsp(lat, ok);
        check_eq("t5_second_latency", 32'(lat), 32'd5);
        check_eq("t5_second_data", 32'(rsp_data), 32'h69);
        tick();

        // 6: reset in the middle of READ
        issue_req(17'd100);
        tick();
        tick();
        check_eq("t6_in_read", 32'(sram_cs_n), 32'd0);
        snap_rsp = rsp_cnt;
        reset = 1'b1;
        #1;
        check_eq("t6_rst_cs_n", 32'(sram_cs_n), 32'd1);
        check_eq("t6_rst_oe_n", 32'(sram_oe_n), 32'd1);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_arb_req", 32'(arb_req), 32'd0);
        check_eq("t6_rst_rsp_data", 32'(rsp_data), 32'h00);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("t6_no_rsp_after_abort", 32'(rsp_cnt - snap_rsp), 32'd0);
        issue_req(17'd100);
        wait_rsp(lat, ok);
        check_eq("t6_recover_latency", 32'(lat), 32'd5);
        check_eq("t6_recover_data", 32'(rsp_data), 32'h5A);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
